// File: rtl/serial_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : serial_rx_pkg                                                  |
// | Shared state encoding, line levels and parity helper for the serial      |
// | frame receiver.                                                          |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic IDLE_LVL  = 1'b0;
    localparam logic START_LVL = 1'b1;

    // Callers zero-extend narrower words; the extra zeros do not change the XOR.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage : serial_rx_pkg
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : serial_shift_reg                                               |
// | LSB-first assembly register: each shift puts the new bit at the MSB.     |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift_en,
    input  logic              i_din,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= {i_din, r_q[DATA_W-1:1]};
        end
    end

    assign o_q = r_q;

endmodule : serial_shift_reg
`default_nettype wire

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : serial_frame_receiver                                          |
// | Start/data/stop serial receiver with a one-entry valid/ready buffer.     |
// | Optional even parity bit enabled by SERIAL_RX_PARITY_EN.                 |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_frame_receiver #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    import serial_rx_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [DATA_W-1:0] w_word;
    logic              w_clear;
    logic              w_shift_en;
    logic              w_stop_ok;
    logic              w_par_ok;
    logic              w_good;
    logic              w_load;
    logic              w_accept;

    assign w_clear    = (r_state == IDLE) && (din == START_LVL);
    assign w_shift_en = (r_state == DATA);

    serial_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_clear),
        .i_shift_en (w_shift_en),
        .i_din      (din),
        .o_q        (w_word)
    );

`ifdef SERIAL_RX_PARITY_EN
    logic r_par;
    logic r_parity_err;
    assign w_par_ok   = (even_parity(32'(w_word)) ^ r_par) == 1'b0;
    assign parity_err = r_parity_err;
`else
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    // A good frame only lands when the buffer is free or being drained this edge.
    assign w_stop_ok = (r_state == STOP) && (din == IDLE_LVL);
    assign w_good    = w_stop_ok && w_par_ok;
    assign w_accept  = data_valid && data_ready;
    assign w_load    = w_good && (!data_valid || data_ready);

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bitcnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (din == START_LVL) begin
                        r_state  <= DATA;
                        r_bitcnt <= '0;
                    end
                end
                DATA: begin
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (r_bitcnt == C_LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        r_state <= PARITY;
`else
                        r_state <= STOP;
`endif
                    end
                end
                PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
                    r_par   <= din;
                    r_state <= STOP;
`else
                    r_state <= IDLE;
`endif
                end
                STOP: begin
                    // A high stop bit is an error, never a new start bit.
                    r_state   <= IDLE;
                    frame_err <= (din != IDLE_LVL);
                    overrun   <= w_good && data_valid && !data_ready;
`ifdef SERIAL_RX_PARITY_EN
                    r_parity_err <= w_stop_ok && !w_par_ok;
`endif
                end
                default: r_state <= IDLE;
            endcase

            if (w_load) begin
                data_out   <= w_word;
                data_valid <= 1'b1;
            end else if (w_accept) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule : serial_frame_receiver
`default_nettype wire
